sram_bank_sel: RTL and testbench



---
 rtl/sram_bank_sel_pkg.sv | 12 +
 rtl/sram_bank_sel_bank_ptr.sv | 27 ++
 rtl/sram_bank_sel.sv | 99 +++++++++
 tb/tb_sram_bank_sel.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_sel_pkg.sv
// Shared helpers for the rotating SRAM bank selector: ring-index arithmetic and the bank-count floor.
// No state, no latency, no flow control.
package sram_bank_sel_pkg;

    localparam int MIN_BANKS = 2;

    // Ring successor for any ring size, including non-power-of-two sizes.
    function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sram_bank_sel_bank_ptr.sv
// Wrapping bank index counter with synchronous clear and a configurable reset value.
// One-cycle latency from inc/clear to ptr; it always accepts inc, and clear wins over inc.
module bank_ptr
    import sram_bank_sel_pkg::*;
#(
    parameter int NUM     = 2,
    parameter int W       = 1,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(RST_VAL);
        end else if (clear) begin
            ptr <= W'(RST_VAL);
        end else if (inc) begin
            ptr <= W'(wrap_inc(32'(ptr), NUM));
        end
    end

endmodule

// File: rtl/sram_bank_sel.sv
// N-bank SRAM buffer selector: a full-flag queue between producer and consumer, or a lockstep ring.
// One-cycle latency from any event to its effect; wr_ready/rd_valid come from registered state only.
module sram_bank_sel
    import sram_bank_sel_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int LOCKSTEP  = 0,
    localparam int IDX_W = $clog2(NUM_BANKS),
    localparam int OCC_W = $clog2(NUM_BANKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_stage_trigger,
    input  logic                 status,
    input  logic                 wr_done,
    input  logic                 rd_done,
    input  logic                 flush,
    output logic [IDX_W-1:0]     wr_bank,
    output logic [IDX_W-1:0]     rd_bank,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam int  MODE_QUEUE    = 0;
    localparam int  MODE_LOCKSTEP = 1;
    localparam bit  IS_LOCK       = (LOCKSTEP == MODE_LOCKSTEP);
    localparam bit  IS_QUEUE      = (LOCKSTEP == MODE_QUEUE);
    // Lockstep starts with the writer one bank ahead of the reader.
    localparam int  WR_RST        = IS_LOCK ? 1 : 0;

    if (NUM_BANKS < MIN_BANKS) begin : g_bad_num_banks
        $error("sram_bank_sel: NUM_BANKS must be at least 2");
    end

    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic             stage_adv;
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_rej;
    logic             rd_rej;

    assign wr_ready  = IS_QUEUE ? ~bank_full[wr_ptr] : 1'b1;
    assign rd_valid  = IS_QUEUE ?  bank_full[rd_ptr] : 1'b1;

    assign stage_adv = IS_LOCK  && new_stage_trigger && status;
    assign wr_acc    = IS_QUEUE && wr_done &&  wr_ready;
    assign rd_acc    = IS_QUEUE && rd_done &&  rd_valid;
    assign wr_rej    = IS_QUEUE && wr_done && !wr_ready;
    assign rd_rej    = IS_QUEUE && rd_done && !rd_valid;

    bank_ptr #(.NUM(NUM_BANKS), .W(IDX_W), .RST_VAL(WR_RST)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc | stage_adv),
        .clear (flush),
        .ptr   (wr_ptr)
    );

    bank_ptr #(.NUM(NUM_BANKS), .W(IDX_W), .RST_VAL(0)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc | stage_adv),
        .clear (flush),
        .ptr   (rd_ptr)
    );

    assign wr_bank = wr_ptr;
    assign rd_bank = rd_ptr;

    // An accepted write targets an empty bank and an accepted read a full one,
    // so set and clear can never hit the same bank in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full     <= '0;
            occupancy     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            bank_full     <= '0;
            occupancy     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (wr_acc && wr_ptr == IDX_W'(i)) bank_full[i] <= 1'b1;
                if (rd_acc && rd_ptr == IDX_W'(i)) bank_full[i] <= 1'b0;
            end
            occupancy <= occupancy + OCC_W'(wr_acc) - OCC_W'(rd_acc);
            if (wr_rej) overflow_err  <= 1'b1;
            if (rd_rej) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_bank_sel.sv
// Bench for sram_bank_sel: a 3-bank queue and 2-/4-bank lockstep rings driven by shared inputs.
module tb_sram_bank_sel;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic new_stage_trigger = 1'b0;
    logic status            = 1'b0;
    logic wr_done           = 1'b0;
    logic rd_done           = 1'b0;
    logic flush             = 1'b0;

    logic [1:0] q_wr_bank, q_rd_bank, q_occ;
    logic [2:0] q_full;
    logic       q_wr_ready, q_rd_valid, q_ovf, q_udf;

    logic [0:0] l2_wr_bank, l2_rd_bank;
    logic [1:0] l2_occ, l2_full;
    logic       l2_wr_ready, l2_rd_valid, l2_ovf, l2_udf;

    logic [1:0] l4_wr_bank, l4_rd_bank;
    logic [2:0] l4_occ;
    logic [3:0] l4_full;
    logic       l4_wr_ready, l4_rd_valid, l4_ovf, l4_udf;

    sram_bank_sel #(.NUM_BANKS(3), .LOCKSTEP(0)) u_q3 (
        .clk(clk), .rst_n(rst_n), .new_stage_trigger(new_stage_trigger), .status(status),
        .wr_done(wr_done), .rd_done(rd_done), .flush(flush),
        .wr_bank(q_wr_bank), .rd_bank(q_rd_bank), .wr_ready(q_wr_ready), .rd_valid(q_rd_valid),
        .bank_full(q_full), .occupancy(q_occ), .overflow_err(q_ovf), .underflow_err(q_udf)
    );

    sram_bank_sel #(.NUM_BANKS(2), .LOCKSTEP(1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .new_stage_trigger(new_stage_trigger), .status(status),
        .wr_done(wr_done), .rd_done(rd_done), .flush(flush),
        .wr_bank(l2_wr_bank), .rd_bank(l2_rd_bank), .wr_ready(l2_wr_ready), .rd_valid(l2_rd_valid),
        .bank_full(l2_full), .occupancy(l2_occ), .overflow_err(l2_ovf), .underflow_err(l2_udf)
    );

    sram_bank_sel #(.NUM_BANKS(4), .LOCKSTEP(1)) u_l4 (
        .clk(clk), .rst_n(rst_n), .new_stage_trigger(new_stage_trigger), .status(status),
        .wr_done(wr_done), .rd_done(rd_done), .flush(flush),
        .wr_bank(l4_wr_bank), .rd_bank(l4_rd_bank), .wr_ready(l4_wr_ready), .rd_valid(l4_rd_valid),
        .bank_full(l4_full), .occupancy(l4_occ), .overflow_err(l4_ovf), .underflow_err(l4_udf)
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue as a set of full banks with write/read cursors; lockstep as a stage count.
    bit mfull [3];
    int mwp, mrp;
    bit movf, mudf;
    int stages;

    function automatic int mocc();
        int n = 0;
        for (int i = 0; i < 3; i++) n += int'(mfull[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mfull[i] = 1'b0;
        mwp = 0; mrp = 0; movf = 1'b0; mudf = 1'b0; stages = 0;
    endtask

    task automatic model_edge();
        bit wok, rok;
        if (flush) begin
            model_reset();
        end else begin
            wok = wr_done && !mfull[mwp];
            rok = rd_done &&  mfull[mrp];
            if (wr_done && !wok) movf = 1'b1;
            if (rd_done && !rok) mudf = 1'b1;
            if (wok) begin mfull[mwp] = 1'b1; mwp = (mwp + 1) % 3; end
            if (rok) begin mfull[mrp] = 1'b0; mrp = (mrp + 1) % 3; end
            if (new_stage_trigger && status) stages++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] fexp;
        fexp = '0;
        for (int i = 0; i < 3; i++) fexp[i] = mfull[i];
        chk("q3_wr_bank",  32'(q_wr_bank),  mwp);
        chk("q3_rd_bank",  32'(q_rd_bank),  mrp);
        chk("q3_full",     32'(q_full),     fexp);
        chk("q3_occ",      32'(q_occ),      mocc());
        chk("q3_wr_ready", 32'(q_wr_ready), !mfull[mwp]);
        chk("q3_rd_valid", 32'(q_rd_valid), mfull[mrp]);
        chk("q3_ovf",      32'(q_ovf),      movf);
        chk("q3_udf",      32'(q_udf),      mudf);
        chk("l2_rd_bank",  32'(l2_rd_bank), stages % 2);
        chk("l2_wr_bank",  32'(l2_wr_bank), (stages + 1) % 2);
        chk("l2_static",   {l2_full, l2_occ, l2_wr_ready, l2_rd_valid, l2_ovf, l2_udf}, 32'b0000_1100);
        chk("l4_rd_bank",  32'(l4_rd_bank), stages % 4);
        chk("l4_wr_bank",  32'(l4_wr_bank), (stages + 1) % 4);
        chk("l4_static",   {l4_full, l4_occ, l4_wr_ready, l4_rd_valid, l4_ovf, l4_udf}, 32'b0_0000_0001_100);
    endtask

    task automatic step(input logic w, input logic r, input logic t, input logic s, input logic f);
        @(negedge clk);
        wr_done = w; rd_done = r; new_stage_trigger = t; status = s; flush = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        check_all();

        // Fill and wrap
        step(1, 0, 0, 0, 0); chk("fill_wb1", 32'(q_wr_bank), 1);
        step(1, 0, 0, 0, 0); chk("fill_wb2", 32'(q_wr_bank), 2);
        step(1, 0, 0, 0, 0); chk("fill_wb0", 32'(q_wr_bank), 0);
        chk("fill_full", 32'(q_full), 32'b111);
        chk("fill_occ",  32'(q_occ), 3);
        chk("fill_rdy",  32'(q_wr_ready), 0);
        step(1, 0, 0, 0, 0);
        chk("ovf_set",   32'(q_ovf), 1);
        chk("ovf_hold",  {q_full, q_occ, q_wr_bank}, {3'b111, 2'd3, 2'd0});

        // Drain and underflow
        step(0, 1, 0, 0, 0); chk("drain_rb1", 32'(q_rd_bank), 1);
        step(0, 1, 0, 0, 0); chk("drain_rb2", 32'(q_rd_bank), 2);
        step(0, 1, 0, 0, 0); chk("drain_rb0", 32'(q_rd_bank), 0);
        chk("drain_occ", 32'(q_occ), 0);
        step(0, 1, 0, 0, 0); chk("udf_set",  32'(q_udf), 1);
        step(0, 0, 0, 0, 0); chk("udf_sticky", 32'(q_udf), 1);
        step(0, 0, 0, 0, 1); chk("flush_err", {q_ovf, q_udf}, 0);

        // Simultaneous events at occupancy 1, then at full
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("sim1_occ", 32'(q_occ), 1);
        chk("sim1_ptr", {q_wr_bank, q_rd_bank}, {2'd2, 2'd1});
        chk("sim1_err", {q_ovf, q_udf}, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("sim3_occ_pre", 32'(q_occ), 3);
        step(1, 1, 0, 0, 0);
        chk("sim3_occ", 32'(q_occ), 2);
        chk("sim3_ovf", 32'(q_ovf), 1);

        // Flush overrides a same-cycle write
        step(1, 0, 1, 1, 1);
        chk("flush_pri", {q_occ, q_wr_bank, q_full, l2_wr_bank, l4_rd_bank}, {2'd0, 2'd0, 3'd0, 1'b1, 2'd0});

        // Lockstep rings
        step(0, 0, 1, 1, 0); chk("l2_t1", {l2_rd_bank, l2_wr_bank}, 2'b10);
        step(0, 0, 1, 1, 0); chk("l2_t2", {l2_rd_bank, l2_wr_bank}, 2'b01);
        step(0, 0, 1, 0, 0); chk("l2_hold", {l2_rd_bank, l2_wr_bank}, 2'b01);
        step(0, 0, 1, 1, 0); chk("l4_t3", 32'(l4_rd_bank), 3);
        step(0, 0, 1, 1, 0); chk("l4_t4", {l4_rd_bank, l4_wr_bank}, {2'd0, 2'd1});
        step(0, 0, 1, 1, 0); chk("l4_t5", {l4_rd_bank, l4_wr_bank}, {2'd1, 2'd2});

        // Asynchronous reset in the middle of a cycle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        wr_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q3", {q_wr_bank, q_rd_bank, q_full, q_occ, q_wr_ready, q_rd_valid, q_ovf, q_udf},
            {2'd0, 2'd0, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
